// File: rtl/axis_bram_writer_pkg.sv
// Shared types and derived constants for the stream-to-BRAM frame writer.
package axis_bram_writer_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } wr_state_e;

    function automatic int unsigned addr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/axis_bram_writer_if.sv
// Stream input, BRAM write port and frame handshake of the frame writer.
interface axis_bram_writer_if
    import axis_bram_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = addr_width(256)
);

    logic [DATA_WIDTH-1:0]   DIN;
    logic                    DIN_VALID;
    logic                    DIN_LAST;
    logic                    DIN_ACCEP;
    logic                    BRAM_EN;
    logic [DATA_WIDTH/8-1:0] BRAM_WE;
    logic [ADDR_WIDTH-1:0]   BRAM_ADDR;
    logic [DATA_WIDTH-1:0]   BRAM_DIN;
    logic                    FRAME_DONE;
    logic [ADDR_WIDTH:0]     FRAME_LEN;
    logic                    BUF_RELEASE;
    logic                    OVERFLOW;

    modport slave (
        input  DIN, DIN_VALID, DIN_LAST, BUF_RELEASE,
        output DIN_ACCEP, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN,
               FRAME_DONE, FRAME_LEN, OVERFLOW
    );

    modport master (
        output DIN, DIN_VALID, DIN_LAST, BUF_RELEASE,
        input  DIN_ACCEP, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DIN,
               FRAME_DONE, FRAME_LEN, OVERFLOW
    );

endinterface

// File: rtl/axis_bram_writer.sv
// Writes one stream frame into a BRAM buffer, then holds it until the reader
// releases the buffer. Words arriving while the buffer is held are dropped.
module axis_bram_writer
    import axis_bram_writer_pkg::*;
#(
    parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_BUF_DEPTH          = 256
) (
    input  logic               S_AXIS_ACLK,
    input  logic               S_AXIS_ARESET,
    axis_bram_writer_if.slave  bus
);

    localparam int unsigned C_ADDR_WIDTH = addr_width(C_BUF_DEPTH);
    localparam int unsigned CW           = C_ADDR_WIDTH + 1;
    localparam int unsigned WE_W         = C_S_AXIS_TDATA_WIDTH / 8;
    localparam logic [CW-1:0] DEPTH_C    = CW'(C_BUF_DEPTH);

    wr_state_e                       state, state_nxt;
    logic [CW-1:0]                   wr_count;
    logic [CW-1:0]                   wr_count_inc;
    logic [CW:0]                     fill_next;
    logic                            accep;
    logic                            take;
    logic                            frame_end;
    logic                            drop;
    logic                            release_buf;

    logic                            bram_en;
    logic [WE_W-1:0]                 bram_we;
    logic [C_ADDR_WIDTH-1:0]         bram_addr;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] bram_din;
    logic                            frame_done;
    logic [CW-1:0]                   frame_len;
    logic                            overflow;

    assign wr_count_inc = wr_count + CW'(1);
    assign fill_next    = {1'b0, wr_count} + (CW+1)'(bus.DIN_VALID);

    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) state <= FILL;
        else               state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        accep       = 1'b0;
        take        = 1'b0;
        frame_end   = 1'b0;
        drop        = 1'b0;
        release_buf = 1'b0;
        unique case (state)
            FILL: begin
                accep = ~S_AXIS_ARESET && (fill_next < {1'b0, DEPTH_C});
                if (bus.DIN_VALID) begin
                    take = 1'b1;
                    // A full buffer closes the frame even without LAST.
                    if (bus.DIN_LAST || wr_count_inc == DEPTH_C) begin
                        frame_end = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                drop = bus.DIN_VALID;
                if (bus.BUF_RELEASE) begin
                    release_buf = 1'b1;
                    state_nxt   = FILL;
                end
            end
        endcase
    end

    // Reset takes priority, so a word sampled with reset never reaches the BRAM.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            wr_count   <= '0;
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_din   <= '0;
            frame_done <= 1'b0;
            frame_len  <= '0;
            overflow   <= 1'b0;
        end else begin
            bram_en <= take;
            bram_we <= {WE_W{take}};
            if (take) begin
                bram_addr <= wr_count[C_ADDR_WIDTH-1:0];
                bram_din  <= bus.DIN;
                wr_count  <= wr_count_inc;
            end else if (release_buf) begin
                wr_count <= '0;
            end
            if (frame_end) begin
                frame_done <= 1'b1;
                frame_len  <= wr_count_inc;
            end else if (release_buf) begin
                frame_done <= 1'b0;
            end
            if (drop) overflow <= 1'b1;
        end
    end

    assign bus.DIN_ACCEP  = accep;
    assign bus.BRAM_EN    = bram_en;
    assign bus.BRAM_WE    = bram_we;
    assign bus.BRAM_ADDR  = bram_addr;
    assign bus.BRAM_DIN   = bram_din;
    assign bus.FRAME_DONE = frame_done;
    assign bus.FRAME_LEN  = frame_len;
    assign bus.OVERFLOW   = overflow;

endmodule

// File: tb/tb_axis_bram_writer.sv
// Directed bench for axis_bram_writer with an 8-word buffer and 32-bit words.
module tb_axis_bram_writer;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axis_bram_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axis_bram_writer #(
        .C_S_AXIS_TDATA_WIDTH(DW),
        .C_BUF_DEPTH(DEPTH)
    ) dut (
        .S_AXIS_ACLK(clk),
        .S_AXIS_ARESET(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int unsigned passed = 0;
    int unsigned total  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic v, input logic l, input logic r);
        bus.DIN         = d;
        bus.DIN_VALID   = v;
        bus.DIN_LAST    = l;
        bus.BUF_RELEASE = r;
    endtask

    task automatic chk_write(input string tag, input int unsigned addr, input logic [31:0] data);
        chk({tag, "_en"},   64'(bus.BRAM_EN),   64'd1);
        chk({tag, "_we"},   64'(bus.BRAM_WE),   64'hF);
        chk({tag, "_addr"}, 64'(bus.BRAM_ADDR), 64'(addr));
        chk({tag, "_din"},  64'(bus.BRAM_DIN),  64'(data));
    endtask

    task automatic chk_nowrite(input string tag);
        chk({tag, "_en"}, 64'(bus.BRAM_EN), 64'd0);
        chk({tag, "_we"}, 64'(bus.BRAM_WE), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_nowrite(tag);
        chk({tag, "_addr"}, 64'(bus.BRAM_ADDR),  64'd0);
        chk({tag, "_din"},  64'(bus.BRAM_DIN),   64'd0);
        chk({tag, "_done"}, 64'(bus.FRAME_DONE), 64'd0);
        chk({tag, "_len"},  64'(bus.FRAME_LEN),  64'd0);
        chk({tag, "_ovf"},  64'(bus.OVERFLOW),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        cyc();
        // Reset: acceptance blocked even with a valid word, and no write occurs.
        drive(32'hDEAD, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rst_accep", 64'(bus.DIN_ACCEP), 64'd0);
        cyc();
        chk_reset_vals("rst");
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("idle_accep", 64'(bus.DIN_ACCEP), 64'd1);

        // Five-word frame 0x10..0x14, LAST on the fifth.
        for (int i = 0; i < 5; i++) begin
            drive(32'h10 + 32'(i), 1'b1, (i == 4), 1'b0);
            cyc();
            chk_write("f5", i, 32'h10 + 32'(i));
            chk("f5_done", 64'(bus.FRAME_DONE), 64'(i == 4));
        end
        chk("f5_len", 64'(bus.FRAME_LEN), 64'd5);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("hold_accep", 64'(bus.DIN_ACCEP), 64'd0);
        cyc();
        chk_nowrite("hold_idle");

        // Word in HOLD is dropped and flags overflow.
        drive(32'hBAD, 1'b1, 1'b0, 1'b0);
        cyc();
        chk_nowrite("hold_drop");
        chk("hold_drop_ovf",  64'(bus.OVERFLOW),   64'd1);
        chk("hold_drop_done", 64'(bus.FRAME_DONE), 64'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        cyc();
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("rel_done",  64'(bus.FRAME_DONE), 64'd0);
        chk("rel_ovf",   64'(bus.OVERFLOW),   64'd1);
        chk("rel_accep", 64'(bus.DIN_ACCEP),  64'd1);

        // Three-word frame restarts at address 0.
        for (int i = 0; i < 3; i++) begin
            drive(32'hA0 + 32'(i), 1'b1, (i == 2), 1'b0);
            cyc();
            chk_write("f3", i, 32'hA0 + 32'(i));
        end
        chk("f3_done", 64'(bus.FRAME_DONE), 64'd1);
        chk("f3_len",  64'(bus.FRAME_LEN),  64'd3);

        // Valid coincident with release in HOLD is dropped.
        drive(32'hEE, 1'b1, 1'b0, 1'b1);
        cyc();
        chk_nowrite("relv");
        chk("relv_done", 64'(bus.FRAME_DONE), 64'd0);
        chk("relv_ovf",  64'(bus.OVERFLOW),   64'd1);

        // Release in FILL and LAST without VALID are both ignored.
        for (int i = 0; i < 2; i++) begin
            drive(32'hC0 + 32'(i), 1'b1, 1'b0, 1'b0);
            cyc();
            chk_write("fr", i, 32'hC0 + 32'(i));
        end
        drive(32'h0, 1'b0, 1'b1, 1'b1);
        cyc();
        chk_nowrite("fr_ign");
        chk("fr_ign_done", 64'(bus.FRAME_DONE), 64'd0);
        drive(32'hC2, 1'b1, 1'b1, 1'b0);
        cyc();
        chk_write("fr_last", 2, 32'hC2);
        chk("fr_done", 64'(bus.FRAME_DONE), 64'd1);
        chk("fr_len",  64'(bus.FRAME_LEN),  64'd3);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        cyc();

        // Reset sampled together with the third word of a frame.
        for (int i = 0; i < 2; i++) begin
            drive(32'h30 + 32'(i), 1'b1, 1'b0, 1'b0);
            cyc();
            chk_write("rm", i, 32'h30 + 32'(i));
        end
        drive(32'h32, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        chk_reset_vals("rm_rst");
        rst = 1'b0;
        drive(32'h40, 1'b1, 1'b1, 1'b0);
        cyc();
        chk_write("rm_next", 0, 32'h40);
        chk("rm_next_len", 64'(bus.FRAME_LEN), 64'd1);
        drive(32'h0, 1'b0, 1'b0, 1'b1);
        cyc();

        // Continuous valid without LAST fills the buffer exactly.
        for (int i = 0; i < 8; i++) begin
            drive(32'h50 + 32'(i), 1'b1, 1'b0, 1'b0);
            #1;
            chk("full_accep", 64'(bus.DIN_ACCEP), 64'(i < 7));
            cyc();
            chk_write("full", i, 32'h50 + 32'(i));
            chk("full_done", 64'(bus.FRAME_DONE), 64'(i == 7));
        end
        chk("full_len", 64'(bus.FRAME_LEN), 64'd8);
        chk("full_ovf", 64'(bus.OVERFLOW),  64'd0);
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_nowrite("full_after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
